axis_broadcast: RTL and testbench
=================================

AXIS_BROADCAST -- requirements
Module: axis_broadcast

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning:
- NMASTERS, 2, number of output streams.
- DATA_WIDTH, 64, tdata width.
- HAS_DEST, 0, dest carried to outputs.
- HAS_ID, 0, id carried to outputs.
- HAS_LAST, 0, last carried to outputs and packet tracking enabled.
- DEST_WIDTH, 1, dest width.
- ID_WIDTH, 1, id width.
- MASK_FROM_DEST, 0, 1 = s_dest[NMASTERS-1:0] is the per-master delivery mask (requires DEST_WIDTH >= NMASTERS).

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning:
- aclk, in, 1, clock.
- aresetn, in, 1, async active-low reset.
- s_valid, in, 1, input valid.
- s_ready, out, 1, input ready.
- s_data, in, DATA_WIDTH, input data.
- s_dest, in, DEST_WIDTH, input dest.
- s_id, in, ID_WIDTH, input id.
- s_last, in, 1, input last.
- m_valid, out, NMASTERS, per-master valid.
- m_ready, in, NMASTERS, per-master ready.
- m_data, out, NMASTERS*DATA_WIDTH, replicated data; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- m_dest, out, NMASTERS*DEST_WIDTH, replicated dest.
- m_id, out, NMASTERS*ID_WIDTH, replicated id.
- m_last, out, NMASTERS, replicated last.

REQ-003 One clock domain, aclk, rising edge; aresetn is asynchronous assert, active-low.

Function
REQ-004 One-entry holding register: data, dest, id, last, plus pending[NMASTERS] (masters that have not yet accepted the held beat); full = |pending.
REQ-005 m_valid[i] = pending[i]; all m_data/m_dest/m_id/m_last slices SHALL be driven from the same held beat.
REQ-006 A master handshake (m_valid[i] & m_ready[i]) SHALL clear pending[i] at that edge; each master receives each beat exactly once.
REQ-007 s_ready = ~full | (pending & ~m_ready) == 0, so a new beat loads in the same cycle the last outstanding master accepts; all masters ready gives 1 beat/cycle.
REQ-008 Latency SHALL be 1 cycle, input handshake to m_valid high.
REQ-009 On input handshake, pending SHALL load the effective mask: all-ones if MASK_FROM_DEST=0, otherwise the packet mask (REQ-010).
REQ-010 If MASK_FROM_DEST=1 and HAS_LAST=1, the block SHALL implement FSM HEAD/BODY:
- Mask is latched from s_dest on the HEAD beat and applied to every beat of the packet.
- HEAD->BODY on an accepted beat with s_last=0; BODY->HEAD on an accepted beat with s_last=1.
- A HEAD beat with s_last=1 stays in HEAD.
REQ-011 If MASK_FROM_DEST=1 and HAS_LAST=0, the mask SHALL be taken from s_dest on every beat.
REQ-012 A beat with effective mask 0 SHALL be consumed (s_ready per REQ-007) and discarded; it updates the FSM but sets no pending bit.
REQ-013 When HAS_DEST/HAS_ID/HAS_LAST is 0, the corresponding outputs SHALL be driven to 0 (m_last = 1 when HAS_LAST=0).
REQ-014 Masters with m_ready held low SHALL stall only the input, never other masters' completion of the current beat.
REQ-015 The held beat SHALL remain stable on all m_* while any pending bit is set.

Reset
REQ-016 While aresetn=0: pending=0, m_valid=0, FSM=HEAD, held fields=0; s_ready=1 one cycle after deassertion at the latest.
REQ-017 Reset asserted mid-packet or with pending beats SHALL drop them; the first beat after reset is treated as HEAD.

Verification
REQ-018 NMASTERS=2, m_ready=2'b11, stream 0x1..0x4 back-to-back -> each master sees 0x1..0x4, one per cycle, first m_valid 1 cycle after the first s handshake.
REQ-019 Beat 0xA, m_ready[0]=1, m_ready[1]=0 for 3 cycles -> master0 takes 0xA once, m_valid[0] drops, s_ready=0 for 3 cycles, master1 takes 0xA on cycle 4 with s_ready=1 in that same cycle.
REQ-020 MASK_FROM_DEST=1, HAS_LAST=1, packet dest=2'b10 with 3 beats (dest changes to 2'b01 on beat 2) -> only master1 receives all 3 beats; m_valid[0] never high.
REQ-021 Beat with dest mask 0 -> s_ready=1, m_valid stays 0, the next beat is delivered normally.
REQ-022 aresetn pulsed low while pending=2'b01 mid-packet -> m_valid=0 immediately; the next beat uses a fresh HEAD mask.
REQ-023 Random m_ready and s_valid over 10k beats -> per-master scoreboard: every beat is delivered exactly once, in order, with no loss or duplication.

Source files
------------

// File: rtl/axis_broadcast.sv
// AXI-Stream one-to-many broadcast with a single holding register.
// Each master takes every held beat exactly once; an optional dest mask selects which masters receive it.
module axis_broadcast #(
  parameter int unsigned NMASTERS       = 2,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned HAS_DEST       = 0,
  parameter int unsigned HAS_ID         = 0,
  parameter int unsigned HAS_LAST       = 0,
  parameter int unsigned DEST_WIDTH     = 1,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned MASK_FROM_DEST = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic [DEST_WIDTH-1:0]          s_dest,
  input  logic [ID_WIDTH-1:0]            s_id,
  input  logic                           s_last,
  output logic [NMASTERS-1:0]            m_valid,
  input  logic [NMASTERS-1:0]            m_ready,
  output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
  output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
  output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
  output logic [NMASTERS-1:0]            m_last
);

  localparam int unsigned XW = (DEST_WIDTH > NMASTERS) ? DEST_WIDTH : NMASTERS;

  typedef enum logic {HEAD, BODY} state_t;

  state_t                  state, state_nx;
  logic [NMASTERS-1:0]     pending, pending_nx;
  logic [NMASTERS-1:0]     mask_q, mask_eff, dest_mask;
  logic [XW-1:0]           dest_ext;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [DEST_WIDTH-1:0]   hold_dest;
  logic [ID_WIDTH-1:0]     hold_id;
  logic                    hold_last;
  logic                    accept;

  // Ready as soon as every still-pending master is accepting this cycle.
  assign s_ready   = ~|(pending & ~m_ready);
  assign accept    = s_valid & s_ready;
  assign dest_ext  = XW'(s_dest);
  assign dest_mask = dest_ext[NMASTERS-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= HEAD;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept && HAS_LAST != 0 && MASK_FROM_DEST != 0)
      state_nx = s_last ? HEAD : BODY;
  end

  always_comb begin
    if (MASK_FROM_DEST == 0)
      mask_eff = '1;
    else if (HAS_LAST != 0 && state == BODY)
      mask_eff = mask_q;
    else
      mask_eff = dest_mask;
  end

  // On accept every outstanding bit is being cleared anyway, so the new mask simply replaces it.
  always_comb begin
    pending_nx = pending & ~m_ready;
    if (accept) pending_nx = mask_eff;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending   <= '0;
      mask_q    <= '0;
      hold_data <= '0;
      hold_dest <= '0;
      hold_id   <= '0;
      hold_last <= 1'b0;
    end else begin
      pending <= pending_nx;
      if (accept) begin
        hold_data <= s_data;
        hold_dest <= s_dest;
        hold_id   <= s_id;
        hold_last <= s_last;
        if (state == HEAD) mask_q <= dest_mask;
      end
    end
  end

  assign m_valid = pending;

  always_comb begin
    m_data = '0;
    m_dest = '0;
    m_id   = '0;
    m_last = '0;
    for (int unsigned i = 0; i < NMASTERS; i++) begin
      m_data[i*DATA_WIDTH +: DATA_WIDTH] = hold_data;
      m_dest[i*DEST_WIDTH +: DEST_WIDTH] = (HAS_DEST != 0) ? hold_dest : '0;
      m_id[i*ID_WIDTH +: ID_WIDTH]       = (HAS_ID != 0) ? hold_id : '0;
      m_last[i]                          = (HAS_LAST != 0) ? hold_last : 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_broadcast.sv
// Bench for axis_broadcast: plain broadcast instance (a) and dest-masked packet instance (b),
// directed scenarios followed by a randomized run checked against per-master queues.
module tb_axis_broadcast;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // Instance a: default parameters (broadcast to all, no dest/id/last)
  logic         a_s_valid, a_s_ready, a_s_last;
  logic [63:0]  a_s_data;
  logic [0:0]   a_s_dest, a_s_id;
  logic [1:0]   a_m_valid, a_m_ready, a_m_last;
  logic [127:0] a_m_data;
  logic [1:0]   a_m_dest, a_m_id;

  axis_broadcast dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_dest(a_s_dest), .s_id(a_s_id), .s_last(a_s_last),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_dest(a_m_dest), .m_id(a_m_id), .m_last(a_m_last)
  );

  // Instance b: mask from dest with packet tracking
  logic        b_s_valid, b_s_ready, b_s_last;
  logic [15:0] b_s_data;
  logic [1:0]  b_s_dest;
  logic [2:0]  b_s_id;
  logic [1:0]  b_m_valid, b_m_ready, b_m_last;
  logic [31:0] b_m_data;
  logic [3:0]  b_m_dest;
  logic [5:0]  b_m_id;

  axis_broadcast #(
    .NMASTERS(2), .DATA_WIDTH(16), .HAS_DEST(1), .HAS_ID(1), .HAS_LAST(1),
    .DEST_WIDTH(2), .ID_WIDTH(3), .MASK_FROM_DEST(1)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_dest(b_s_dest), .s_id(b_s_id), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_dest(b_m_dest), .m_id(b_m_id), .m_last(b_m_last)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  dest;
    logic [2:0]  id;
    logic        last;
  } beat_t;

  beat_t      q [2][$];
  bit         in_body;
  logic [1:0] pkt_mask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_b(input logic v, input logic [15:0] d, input logic [1:0] dst,
                         input logic l, input logic [1:0] rdy);
    b_s_valid = v;
    b_s_data  = d;
    b_s_dest  = dst;
    b_s_id    = d[2:0];
    b_s_last  = l;
    b_m_ready = rdy;
  endtask

  // One randomized cycle on instance b, checked against the queue model.
  task automatic rand_cycle(input bit allow_valid, inout int accepted);
    logic [1:0] exp_v;
    logic       exp_r;
    logic [1:0] mask;
    beat_t      b;
    @(posedge aclk); #1;
    drive_b(allow_valid && ($urandom % 4 != 0), 16'($urandom), 2'($urandom_range(0, 3)),
            ($urandom % 4 == 0), 2'($urandom));
    @(negedge aclk);
    exp_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = (q[i].size() != 0);
      if (exp_v[i] && !b_m_ready[i]) exp_r = 1'b0;
    end
    check("rand_m_valid", b_m_valid, exp_v);
    check("rand_s_ready", b_s_ready, exp_r);
    for (int i = 0; i < 2; i++) begin
      if (exp_v[i] && b_m_ready[i]) begin
        b = q[i].pop_front();
        check("rand_data", b_m_data[i*16 +: 16], b.data);
        check("rand_dest", b_m_dest[i*2 +: 2], b.dest);
        check("rand_id", b_m_id[i*3 +: 3], b.id);
        check("rand_last", b_m_last[i], b.last);
      end
    end
    if (b_s_valid && exp_r) begin
      mask = in_body ? pkt_mask : b_s_dest;
      if (!in_body) pkt_mask = b_s_dest;
      in_body = !b_s_last;
      b = '{data: b_s_data, dest: b_s_dest, id: b_s_id, last: b_s_last};
      for (int i = 0; i < 2; i++)
        if (mask[i]) q[i].push_back(b);
      accepted++;
    end
  endtask

  logic [1:0]  t_mr  [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
  logic        t_sv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] t_sd  [7] = '{64'hA, 64'hB, 64'hB, 64'hB, 64'hB, 64'h0, 64'h0};
  logic [1:0]  t_ev  [7] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
  logic        t_er  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0]  p_dst [3] = '{2'b10, 2'b01, 2'b01};
  logic        p_lst [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int accepted;
    aresetn   = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_dest = '0; a_s_id = '0; a_s_last = 1'b0;
    a_m_ready = 2'b00;
    drive_b(1'b0, '0, '0, 1'b0, 2'b00);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_a_valid", a_m_valid, 2'b00);
    check("rst_a_sready", a_s_ready, 1'b1);
    check("rst_a_last", a_m_last, 2'b11);
    check("rst_a_dest", a_m_dest, 2'b00);
    check("rst_a_id", a_m_id, 2'b00);
    check("rst_b_valid", b_m_valid, 2'b00);
    check("rst_b_data", b_m_data, 32'h0);
    check("rst_b_dest", b_m_dest, 4'h0);
    aresetn = 1'b1;

    // Back-to-back stream 1..4, all masters ready
    for (int k = 1; k <= 6; k++) begin
      @(posedge aclk); #1;
      a_m_ready = 2'b11;
      a_s_valid = (k <= 4);
      a_s_data  = 64'(k);
      @(negedge aclk);
      check("bcast_valid", a_m_valid, (k >= 2 && k <= 5) ? 2'b11 : 2'b00);
      check("bcast_sready", a_s_ready, 1'b1);
      if (k >= 2 && k <= 5) begin
        check("bcast_d0", a_m_data[63:0], 64'(k - 1));
        check("bcast_d1", a_m_data[127:64], 64'(k - 1));
        check("bcast_last", a_m_last, 2'b11);
      end
    end

    // Master 1 stalls for 3 cycles on beat 0xA, beat 0xB waits behind it
    for (int c = 0; c < 7; c++) begin
      @(posedge aclk); #1;
      a_m_ready = t_mr[c];
      a_s_valid = t_sv[c];
      a_s_data  = t_sd[c];
      @(negedge aclk);
      check("stall_valid", a_m_valid, t_ev[c]);
      check("stall_sready", a_s_ready, t_er[c]);
      if (c == 1) check("stall_m0_data", a_m_data[63:0], 64'hA);
      if (c == 4) check("stall_m1_data", a_m_data[127:64], 64'hA);
      if (c == 5) check("stall_next_data", a_m_data, {64'hB, 64'hB});
    end

    // Packet with head dest 2'b10, later beats carry 2'b01
    for (int k = 1; k <= 5; k++) begin
      @(posedge aclk); #1;
      if (k <= 3) drive_b(1'b1, 16'(k), p_dst[k-1], p_lst[k-1], 2'b11);
      else        drive_b(1'b0, '0, '0, 1'b0, 2'b11);
      @(negedge aclk);
      check("pkt_valid", b_m_valid, (k >= 2 && k <= 4) ? 2'b10 : 2'b00);
      if (k >= 2 && k <= 4) begin
        check("pkt_data", b_m_data[31:16], 16'(k - 1));
        check("pkt_dest", b_m_dest[3:2], p_dst[k-2]);
        check("pkt_last", b_m_last[1], p_lst[k-2]);
        check("pkt_id", b_m_id[5:3], 3'(k - 1));
      end
    end

    // Zero-mask beat is swallowed, next beat goes through
    @(posedge aclk); #1; drive_b(1'b1, 16'h55, 2'b00, 1'b1, 2'b11);
    @(negedge aclk);
    check("zmask_sready", b_s_ready, 1'b1);
    check("zmask_idle", b_m_valid, 2'b00);
    @(posedge aclk); #1; drive_b(1'b1, 16'h66, 2'b11, 1'b1, 2'b11);
    @(negedge aclk);
    check("zmask_dropped", b_m_valid, 2'b00);
    @(posedge aclk); #1; drive_b(1'b0, '0, '0, 1'b0, 2'b11);
    @(negedge aclk);
    check("zmask_next_valid", b_m_valid, 2'b11);
    check("zmask_next_data", b_m_data, {16'h66, 16'h66});

    // Reset mid-packet with master 0 pending
    @(posedge aclk); #1; drive_b(1'b1, 16'h77, 2'b01, 1'b0, 2'b00);
    @(negedge aclk);
    @(posedge aclk); #1; drive_b(1'b0, '0, '0, 1'b0, 2'b00);
    @(negedge aclk);
    check("midrst_pending", b_m_valid, 2'b01);
    #1 aresetn = 1'b0;
    #1;
    check("midrst_valid_drop", b_m_valid, 2'b00);
    check("midrst_sready", b_s_ready, 1'b1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    drive_b(1'b1, 16'h88, 2'b10, 1'b1, 2'b11);
    @(negedge aclk);
    check("midrst_accept", b_s_ready, 1'b1);
    @(posedge aclk); #1; drive_b(1'b0, '0, '0, 1'b0, 2'b11);
    @(negedge aclk);
    check("midrst_fresh_head", b_m_valid, 2'b10);
    check("midrst_data", b_m_data[31:16], 16'h88);

    // Randomized traffic against the queue model
    @(posedge aclk); #1;
    drive_b(1'b0, '0, '0, 1'b0, 2'b00);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn  = 1'b1;
    in_body  = 1'b0;
    pkt_mask = 2'b00;
    accepted = 0;
    for (int c = 0; c < 60000 && accepted < 10000; c++)
      rand_cycle(1'b1, accepted);
    check("rand_beats", accepted, 10000);
    for (int c = 0; c < 20; c++)
      rand_cycle(1'b0, accepted);
    check("rand_q0_drained", q[0].size(), 0);
    check("rand_q1_drained", q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
